float_mul_nb: RTL and testbench

FLOAT_MUL_NB -- requirements
Module: float_mul_nb

---
 rtl/float_mul_nb.sv | 97 +++++++++
 tb/tb_float_mul_nb.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/float_mul_nb.sv
// Pipelined IEEE 754 single-precision multiplier: one operand pair per cycle, 8-cycle latency.
// Shift-add significand multiply over six stages, round-toward-zero, no special-value handling.
module float_mul_nb (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] din1,
    input  logic [31:0] din2,
    input  logic        din_valid,
    output logic [31:0] dout,
    output logic        dout_valid
);

    // Input capture
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        in_valid_q;

    // Per-stage sideband, index 0 = stage 0 ... index 6 = stage 6
    logic [6:0]  valid_q;
    logic [6:0]  sign_q;
    logic [6:0]  zero_q;
    logic [9:0]  expsum_q [7];

    // Multiplier operands entering stages 1..6, accumulator leaving stages 1..6
    logic [47:0] mcand_q  [6];
    logic [23:0] mplier_q [6];
    logic [47:0] acc_q    [6];
    logic [47:0] pp       [6];

    logic [47:0] prod;
    logic [22:0] norm_man;
    logic [7:0]  norm_exp;
    logic [31:0] result;
    logic        unused_bits;

    // Control path: only valids and the output are reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            in_valid_q <= 1'b0;
            valid_q    <= '0;
            dout_valid <= 1'b0;
            dout       <= '0;
        end else begin
            in_valid_q <= din_valid;
            valid_q    <= {valid_q[5:0], in_valid_q};
            dout_valid <= valid_q[6];
            if (valid_q[6]) begin
                dout <= result;
            end
        end
    end

    // Datapath registers run freely; valid alone qualifies them.
    always_ff @(posedge clk) begin
        a_q <= din1;
        b_q <= din2;

        sign_q      <= {sign_q[5:0], a_q[31] ^ b_q[31]};
        zero_q      <= {zero_q[5:0], (a_q[30:23] == 8'd0) | (b_q[30:23] == 8'd0)};
        expsum_q[0] <= {2'b00, a_q[30:23]} + {2'b00, b_q[30:23]} - 10'd127;
        mcand_q[0]  <= {24'd0, 1'b1, a_q[22:0]};
        mplier_q[0] <= {1'b1, b_q[22:0]};

        acc_q[0] <= pp[0];
        for (int s = 1; s < 6; s++) begin
            mcand_q[s]  <= mcand_q[s-1] << 4;
            mplier_q[s] <= mplier_q[s-1] >> 4;
            acc_q[s]    <= acc_q[s-1] + pp[s];
        end
        for (int s = 1; s < 7; s++) begin
            expsum_q[s] <= expsum_q[s-1];
        end
    end

    // Each stage retires the low nibble of its multiplier against the pre-shifted multiplicand.
    always_comb begin
        for (int s = 0; s < 6; s++) begin
            pp[s] = '0;
            for (int b = 0; b < 4; b++) begin
                if (mplier_q[s][b]) begin
                    pp[s] = pp[s] + (mcand_q[s] << b);
                end
            end
        end
    end

    // Normalize and truncate; exponent wraps to 8 bits without saturation.
    always_comb begin
        prod     = acc_q[5];
        norm_man = prod[47] ? prod[46:24] : prod[45:23];
        norm_exp = expsum_q[6][7:0] + {7'd0, prod[47]};
        result   = zero_q[6] ? 32'h0000_0000 : {sign_q[6], norm_exp, norm_man};
    end

    assign unused_bits = ^{prod[22:0], expsum_q[6][9:8], mplier_q[5][23:4]};

endmodule

// File: tb/tb_float_mul_nb.sv
// Directed bench for float_mul_nb: latency, normalization, sign, truncation, zero,
// exponent wrap, streaming with gaps, and reset mid-pipeline.
module tb_float_mul_nb;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic [31:0] din1 = '0;
    logic [31:0] din2 = '0;
    logic        din_valid = 1'b0;
    logic [31:0] dout;
    logic        dout_valid;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    float_mul_nb dut (
        .clk        (clk),
        .nrst       (nrst),
        .din1       (din1),
        .din2       (din2),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    // Spec-level reference: full-width product, 8-bit wrapping exponent, truncation.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [7:0]  e;
        logic [22:0] m;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'h0;
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = a[30:23] + b[30:23] - 8'd127 + {7'd0, p[47]};
        m = 23'(p >> (p[47] ? 24 : 23));
        return {a[31] ^ b[31], e, m};
    endfunction

    // One operand pair, then wait (bounded) for the first dout_valid.
    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] want);
        int lat;
        din1      = a;
        din2      = b;
        din_valid = 1'b1;
        @(posedge clk);
        #1 din_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (dout_valid) begin
                lat = i;
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'd8);
        check(tag, dout, want);
    endtask

    logic [15:0] pat = 16'b1111_0110_1011_1101;
    logic [31:0] sa [16];
    logic [31:0] sb [16];

    initial begin
        #2 nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", dout, 32'h0);
        check("rst_valid", {31'd0, dout_valid}, 32'd0);
        nrst = 1'b1;

        run_one("mul_2x3", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
        @(posedge clk);
        #1;
        check("pulse_once", {31'd0, dout_valid}, 32'd0);
        check("dout_hold", dout, 32'h40C0_0000);

        run_one("norm_1p5sq", 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
        run_one("sign_neg", 32'hC080_0000, 32'h3F00_0000, 32'hC000_0000);
        run_one("trunc_lsb", 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002);
        run_one("max_man", 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE);
        run_one("zero_a", 32'h0000_0000, 32'hC040_0000, 32'h0000_0000);
        run_one("denorm_a", 32'h0040_0000, 32'h4000_0000, 32'h0000_0000);
        run_one("exp_wrap", 32'h7F00_0000, 32'h7F00_0000, 32'h3E80_0000);

        for (int i = 0; i < 16; i++) begin
            sa[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)};
            sb[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)};
        end
        for (int k = 0; k < 24; k++) begin
            if (k < 16) begin
                din1      = sa[k];
                din2      = sb[k];
                din_valid = pat[15-k];
            end else begin
                din_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (k >= 8) begin
                check("stream_v", {31'd0, dout_valid}, {31'd0, pat[15-(k-8)]});
                if (pat[15-(k-8)]) check("stream_d", dout, ref_mul(sa[k-8], sb[k-8]));
            end else begin
                check("stream_idle", {31'd0, dout_valid}, 32'd0);
            end
        end

        // Five back-to-back inputs, reset asserted for edges 3 and 4.
        for (int k = 0; k < 5; k++) begin
            din1      = 32'h4000_0000 + 32'(k);
            din2      = 32'h3FC0_0000;
            din_valid = 1'b1;
            if (k == 3) begin
                nrst = 1'b0;
                #1;
                check("midrst_dout", dout, 32'h0);
                check("midrst_valid", {31'd0, dout_valid}, 32'd0);
            end
            @(posedge clk);
            #1;
        end
        din_valid = 1'b0;
        nrst      = 1'b1;
        // Any surviving in-flight pulse would show up before latency 8 here.
        run_one("post_rst", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_idle", {31'd0, dout_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
